// File: rtl/nw_pair_loader.sv
// rtl/nw_pair_loader.sv - loads top/left string pairs from a beat stream and issues them to the alignment grid
module nw_pair_loader #(
  parameter int S_LEN    = 64,
  parameter int C_WIDTH  = 2,
  parameter int IN_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                num_pairs,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       grid_valid,
  output logic [S_LEN*C_WIDTH-1:0]   t_str,
  output logic [S_LEN*C_WIDTH-1:0]   l_str,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                pairs_issued
);

  localparam int SW    = S_LEN * C_WIDTH;
  localparam int BEATS = SW / IN_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // A string must split into a whole number of input beats.
  if ((SW % IN_WIDTH) != 0) begin : g_width_check
    $error("nw_pair_loader: S_LEN*C_WIDTH must be a multiple of IN_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_T = 3'd1,
    LOAD_L = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   beat_cnt;
  logic [31:0]     num_lat;
  logic [SW-1:0]   t_stage;
  logic [SW-1:0]   l_stage;
  logic [SW-1:0]   l_merged;
  logic            accept;
  logic            last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE, loads advance on the final accepted beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_pairs == 32'd0) ? DONE : LOAD_T;
        end
      end
      LOAD_T: begin
        if (accept && last_beat) begin
          state_nxt = LOAD_L;
        end
      end
      LOAD_L: begin
        if (accept && last_beat) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = ((pairs_issued + 32'd1) == num_lat) ? DONE : LOAD_T;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from state so in_ready never follows in_valid.
  always_comb begin
    in_ready   = 1'b0;
    grid_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE:    busy       = 1'b0;
      LOAD_T:  in_ready   = 1'b1;
      LOAD_L:  in_ready   = 1'b1;
      ISSUE:   grid_valid = 1'b1;
      DONE:    done       = 1'b1;
      default: busy       = 1'b0;
    endcase
  end

  // Left string as it will look once the beat currently on in_data is written.
  always_comb begin
    l_merged = l_stage;
    l_merged[int'(beat_cnt) * IN_WIDTH +: IN_WIDTH] = in_data;
  end

  // Datapath: staging fills, output strings load on the final left beat so they are valid during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      num_lat      <= '0;
      pairs_issued <= '0;
      t_stage      <= '0;
      l_stage      <= '0;
      t_str        <= '0;
      l_str        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_lat      <= num_pairs;
            pairs_issued <= '0;
            beat_cnt     <= '0;
          end
        end
        LOAD_T: begin
          if (accept) begin
            t_stage[int'(beat_cnt) * IN_WIDTH +: IN_WIDTH] <= in_data;
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
          end
        end
        LOAD_L: begin
          if (accept) begin
            l_stage[int'(beat_cnt) * IN_WIDTH +: IN_WIDTH] <= in_data;
            if (last_beat) begin
              beat_cnt <= '0;
              t_str    <= t_stage;
              l_str    <= l_merged;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          pairs_issued <= pairs_issued + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nw_pair_loader.sv
// tb/tb_nw_pair_loader.sv - self-checking bench for nw_pair_loader
module tb_nw_pair_loader;

  localparam int S_LEN    = 64;
  localparam int C_WIDTH  = 2;
  localparam int IN_WIDTH = 64;
  localparam int SW       = S_LEN * C_WIDTH;
  localparam int BEATS    = SW / IN_WIDTH;
  localparam int PAIR_CYC = 2 * BEATS + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [31:0]         num_pairs;
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic                grid_valid;
  logic [SW-1:0]       t_str;
  logic [SW-1:0]       l_str;
  logic                busy;
  logic                done;
  logic [31:0]         pairs_issued;

  nw_pair_loader #(.S_LEN(S_LEN), .C_WIDTH(C_WIDTH), .IN_WIDTH(IN_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pairs(num_pairs),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .grid_valid(grid_valid), .t_str(t_str), .l_str(l_str),
    .busy(busy), .done(done), .pairs_issued(pairs_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] np;
    int          gap;
    bit          timed;
  } vec_t;

  int unsigned         vecs = 0;
  int unsigned         miss = 0;
  logic [IN_WIDTH-1:0] beats[$];
  logic [SW-1:0]       last_t;
  logic [SW-1:0]       last_l;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: beat k of string s of pair p lands at bits [k*IN_WIDTH +: IN_WIDTH].
  function automatic logic [SW-1:0] exp_str(input int p, input int s);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < BEATS; k++) begin
      r[k*IN_WIDTH +: IN_WIDTH] = beats[(p*2 + s)*BEATS + k];
    end
    return r;
  endfunction

  task automatic run_job(input logic [31:0] np, input int gap, input bit timed,
                         input bit fixed, input bit poke, input int stop_after);
    int n;
    int cyc;
    int pidx;
    int bptr;
    bit fin;
    bit poked;
    n = (stop_after > 0) ? stop_after : int'(np);
    beats.delete();
    for (int i = 0; i < n*2*BEATS; i++) begin
      beats.push_back(fixed ? IN_WIDTH'(i + 1) : IN_WIDTH'({$urandom, $urandom}));
    end
    pidx = 0; bptr = 0; fin = 0; poked = 0;
    @(negedge clk);
    start = 1'b1; num_pairs = np; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      if (grid_valid) begin
        if (pidx < n) begin
          chk("t_str", t_str, exp_str(pidx, 0));
          chk("l_str", l_str, exp_str(pidx, 1));
        end else begin
          chk("extra grid_valid", SW'(grid_valid), SW'(1'b0));
        end
        if (timed) chk("issue cycle", SW'(cyc), SW'((pidx + 1) * PAIR_CYC));
        last_t = t_str;
        last_l = l_str;
        pidx++;
        if (stop_after > 0 && pidx == stop_after) fin = 1;
      end else if (pidx > 0) begin
        chk("t_str hold", t_str, last_t);
        chk("l_str hold", l_str, last_l);
      end
      if (np == 32'd0) chk("in_ready idle job", SW'(in_ready), SW'(1'b0));
      if (done) begin
        chk("done pairs_issued", SW'(pairs_issued), SW'(np));
        chk("done strobe count", SW'(pidx), SW'(np));
        if (timed) chk("done cycle", SW'(cyc), SW'((np == 32'd0) ? 1 : int'(np) * PAIR_CYC + 1));
        fin = 1;
      end
      start = 1'b0;
      if (poke && !poked && in_ready && ((bptr / BEATS) % 2 == 1)) begin
        start = 1'b1;
        num_pairs = np + 32'd5;
        poked = 1;
      end
      in_valid = ($urandom_range(99) >= gap);
      if (in_valid && in_ready && bptr < beats.size()) begin
        in_data = beats[bptr];
      end else begin
        in_data = IN_WIDTH'({$urandom, $urandom});
      end
      if (in_valid && in_ready) bptr++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (!fin) begin
      vecs++;
      miss++;
      $display("FAIL job timeout: got no completion expected done within 3000 cycles");
    end else if (stop_after > 0) begin
      chk("mid-job done", SW'(done), SW'(1'b0));
      chk("mid-job busy", SW'(busy), SW'(1'b1));
      chk("mid-job pairs_issued", SW'(pairs_issued), SW'(stop_after));
    end else begin
      chk("idle busy", SW'(busy), SW'(1'b0));
      chk("idle done", SW'(done), SW'(1'b0));
      chk("idle pairs_issued hold", SW'(pairs_issued), SW'(np));
    end
  endtask

  initial begin
    vec_t          tbl[6];
    logic [SW-1:0] c_t;
    logic [SW-1:0] c_l;
    tbl = '{'{32'd1, 0, 1'b1}, '{32'd3, 0, 1'b1}, '{32'd0, 0, 1'b1},
            '{32'd2, 30, 1'b0}, '{32'd5, 0, 1'b1}, '{32'd4, 45, 1'b0}};
    c_t = {64'd2, 64'd1};
    c_l = {64'd4, 64'd3};

    rst = 1'b1; start = 1'b1; num_pairs = 32'd5; in_valid = 1'b1; in_data = '1;
    repeat (3) @(negedge clk);
    chk("reset busy", SW'(busy), SW'(1'b0));
    chk("reset in_ready", SW'(in_ready), SW'(1'b0));
    chk("reset grid_valid", SW'(grid_valid), SW'(1'b0));
    chk("reset done", SW'(done), SW'(1'b0));
    chk("reset pairs_issued", SW'(pairs_issued), SW'(0));
    chk("reset t_str", t_str, '0);
    chk("reset l_str", l_str, '0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    run_job(32'd1, 0, 1'b1, 1'b1, 1'b0, 0);
    chk("fixed t_str", last_t, c_t);
    chk("fixed l_str", last_l, c_l);

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].np, tbl[i].gap, tbl[i].timed, 1'b0, 1'b0, 0);
    end

    run_job(32'd2, 20, 1'b0, 1'b0, 1'b1, 0);

    @(negedge clk);
    start = 1'b1; num_pairs = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      in_valid = 1'b1;
      in_data = IN_WIDTH'({$urandom, $urandom});
      @(negedge clk);
      chk("partial grid_valid", SW'(grid_valid), SW'(1'b0));
    end
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("abort grid_valid", SW'(grid_valid), SW'(1'b0));
    chk("abort done", SW'(done), SW'(1'b0));
    chk("abort busy", SW'(busy), SW'(1'b0));
    chk("abort in_ready", SW'(in_ready), SW'(1'b0));
    chk("abort pairs_issued", SW'(pairs_issued), SW'(0));
    chk("abort t_str", t_str, '0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post-abort grid_valid", SW'(grid_valid), SW'(1'b0));
    chk("post-abort done", SW'(done), SW'(1'b0));
    run_job(32'd1, 0, 1'b1, 1'b1, 1'b0, 0);
    chk("restart t_str", last_t, c_t);
    chk("restart l_str", last_l, c_l);

    run_job(32'hFFFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("max job reset pairs_issued", SW'(pairs_issued), SW'(0));
    chk("max job reset done", SW'(done), SW'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
